// File: rtl/acc_pkg.sv
// Shared constants and helpers for the accumulator sample FIFO slice.
package acc_pkg;

    localparam int unsigned ACC_WIDTH  = 8;
    localparam int unsigned DROP_W_DEF = 8;

    function automatic int unsigned ptr_w(input int unsigned depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/sample_fifo_core.sv
// Circular FIFO storage: pointers, occupancy count and the masked head output.
module sample_fifo_core
    import acc_pkg::*;
#(
    parameter  int unsigned WIDTH = ACC_WIDTH,
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PW    = ptr_w(DEPTH),
    localparam int unsigned CW    = PW + 1
) (
    input  logic             ck,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    // Storage needs no reset: the head is masked to zero whenever count is zero.
    always_ff @(posedge ck) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge ck) begin
        if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        rdata = '0;
        if (count != '0) rdata = mem[rd_ptr];
    end

endmodule

// File: rtl/acc_sample_fifo.sv
// Samples the accumulator into a FIFO; overflow drops samples rather than stalling.
module acc_sample_fifo
    import acc_pkg::*;
#(
    parameter  int unsigned WIDTH  = ACC_WIDTH,
    parameter  int unsigned DEPTH  = 4,
    parameter  int unsigned DROP_W = DROP_W_DEF,
    localparam int unsigned CW     = ptr_w(DEPTH) + 1
) (
    input  logic              ck,
    input  logic              clr,
    input  logic              en,
    input  logic              mode_chg,
    input  logic [WIDTH-1:0]  din,
    input  logic              rd_rdy,
    output logic              rd_vld,
    output logic [WIDTH-1:0]  rd_data,
    output logic [CW-1:0]     count,
    output logic              ovf,
    output logic [DROP_W-1:0] drop_cnt
);

    logic [WIDTH-1:0] last;
    logic             have_last;
    logic             full;
    logic             pop;
    logic             req;
    logic             push;
    logic             drop;

    // A pop on a full FIFO frees the slot in the same edge, so the push still lands.
    always_comb begin
        rd_vld = (count != '0);
        full   = (count == CW'(DEPTH));
        pop    = rd_vld & rd_rdy;
        req    = en & (~mode_chg | ~have_last | (din != last));
        push   = req & (~full | pop);
        drop   = req & full & ~pop;
    end

    always_ff @(posedge ck) begin
        if (clr) begin
            last      <= '0;
            have_last <= 1'b0;
            ovf       <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            if (req) begin
                last      <= din;
                have_last <= 1'b1;
            end
            if (drop) begin
                ovf <= 1'b1;
                if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end

    sample_fifo_core #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_core (
        .ck    (ck),
        .clr   (clr),
        .push  (push),
        .pop   (pop),
        .wdata (din),
        .rdata (rd_data),
        .count (count)
    );

endmodule
